// File: rtl/isp_pkg.sv
// ============================================================================
//  Module      : isp_pkg
//  Description : Shared image-pipeline constants (pixel width, line limits).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isp_pkg;

    localparam int C_PIX_W_DEFAULT = 8;
    localparam int C_MAX_WIDTH     = 4096;

endpackage : isp_pkg

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
//  Module      : line_buffer
//  Description : Single-port line store, one pixel per address, read-before-write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read returns the contents before this edge's write to the same address.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule : line_buffer

`default_nettype wire

// File: rtl/conv_column_feeder.sv
// ============================================================================
//  Module      : conv_column_feeder
//  Description : Turns a raster pixel stream into KERNEL-tall columns.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_column_feeder
    import isp_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int KERNEL = 3,
    parameter int PIX_W  = C_PIX_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    input  logic                    i_sof,
    input  logic [PIX_W-1:0]        i_pixel,
    output logic                    o_valid,
    output logic [KERNEL*PIX_W-1:0] o_data,
    output logic                    o_eol,
    output logic                    o_eof
);

    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(KERNEL);
    localparam logic [X_W-1:0] C_X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(KERNEL - 1);

    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic                    r_valid;
    logic [KERNEL*PIX_W-1:0] r_data;
    logic                    r_eol;
    logic                    r_eof;
    logic                    r_eol_pend;

    logic [X_W-1:0]          w_x;
    logic [Y_W-1:0]          w_y;
    logic                    w_emit;
    logic                    w_last_col;
    logic [KERNEL*PIX_W-1:0] w_column;
    logic [PIX_W-1:0]        w_rdata [KERNEL-1];
    logic [PIX_W-1:0]        w_wdata [KERNEL-1];

    // A start-of-frame pixel restarts counting before it is itself stored.
    always_comb begin
        w_x = r_x;
        w_y = r_y;
        if (i_valid && i_sof) begin
            w_x = '0;
            w_y = '0;
        end
    end

    assign w_emit     = i_valid && (w_y == C_Y_LAST);
    assign w_last_col = (w_x == C_X_LAST);

    for (genvar k = 0; k < KERNEL - 1; k++) begin : g_buf
        if (k == 0) begin : g_head
            assign w_wdata[k] = i_pixel;
        end else begin : g_chain
            assign w_wdata[k] = w_rdata[k-1];
        end

        line_buffer #(
            .DEPTH  (WIDTH),
            .DATA_W (PIX_W),
            .ADDR_W (X_W)
        ) u_line_buffer (
            .clk     (clk),
            .i_we    (i_valid),
            .i_addr  (w_x),
            .i_wdata (w_wdata[k]),
            .o_rdata (w_rdata[k])
        );
    end

    // Field 0 is the live pixel; buffer k (line y-1-k) lands in field k+1.
    always_comb begin
        w_column              = '0;
        w_column[PIX_W-1:0]   = i_pixel;
        for (int k = 0; k < KERNEL - 1; k++) begin
            w_column[(k+1)*PIX_W +: PIX_W] = w_rdata[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_eol      <= 1'b0;
            r_eof      <= 1'b0;
            r_eol_pend <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_eol   <= w_emit && w_last_col;
            r_eof   <= 1'b0;
            if (i_valid) begin
                if (w_emit) begin
                    r_data <= w_column;
                end
                // The frame's final column is only known once the next frame starts.
                r_eof      <= i_sof && r_eol_pend;
                r_eol_pend <= w_emit && w_last_col;
                if (w_last_col) begin
                    r_x <= '0;
                    r_y <= (w_y == C_Y_LAST) ? w_y : w_y + 1'b1;
                end else begin
                    r_x <= w_x + 1'b1;
                    r_y <= w_y;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_eol   = r_eol;
    assign o_eof   = r_eof;

endmodule : conv_column_feeder

`default_nettype wire
